// File: rtl/mem_mgr_pkg.sv
// Shared definitions for the memory channel manager: state encoding,
// channel-index width helper and default bus widths.
package mem_mgr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } mgrState_t;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_SLAVE_W = 2;

  // Channel index width; never below one bit even for two channels
  function automatic int unsigned chW(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_tmo_counter.sv
// Per-read timeout counter: cleared outside a request, counts while enabled,
// flags the cycle on which the count reaches TMO_CYC.
module mem_tmo_counter #(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Clear,
  input  logic Enable,
  output logic Expired
);

  localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clk) begin
    if (!Rst_n || Clear) begin
      count <= '0;
    end else if (Enable) begin
      count <= count + 1'b1;
    end
  end

  // Expires on the cycle whose increment would make the count equal TMO_CYC
  assign Expired = Enable && (count == CNT_W'(TMO_CYC - 1));

endmodule

// File: rtl/mem_channel_manager.sv
// Routes one of NUM_CH memory data sources onto the shared result bus using a
// per-channel req/ack handshake, bounded timeout and optional channel sweep.
module mem_channel_manager
  import mem_mgr_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned SLAVE_W = DEF_SLAVE_W,
  parameter int unsigned TMO_CYC = 255,
  localparam int unsigned CH_W   = chW(NUM_CH)
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     CmdValid,
  output logic                     CmdReady,
  input  logic [CH_W-1:0]          CmdChan,
  input  logic [SLAVE_W-1:0]       CmdSlave,
  input  logic                     CmdSweep,
  output logic [NUM_CH-1:0]        ChReq,
  input  logic [NUM_CH-1:0]        ChAck,
  input  logic [NUM_CH*DATA_W-1:0] ChData,
  output logic [DATA_W-1:0]        MemData,
  output logic [SLAVE_W-1:0]       MemSlave,
  output logic [CH_W-1:0]          MemChan,
  output logic                     MemValid,
  input  logic                     MemReady,
  output logic                     MemErr
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  mgrState_t state, stateNext;

  logic [CH_W-1:0]    chanQ, chanNext, cmdChanClamped;
  logic [SLAVE_W-1:0] slaveQ;
  logic               sweepQ;
  logic               latchCmd, capture, timedOut;
  logic               tmoExpired;

  mem_tmo_counter #(
    .TMO_CYC (TMO_CYC)
  ) uTmo (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Clear   (state != REQ),
    .Enable  (state == REQ),
    .Expired (tmoExpired)
  );

  assign cmdChanClamped = (int'(CmdChan) > int'(NUM_CH - 1)) ? LAST_CH : CmdChan;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    chanNext  = chanQ;
    latchCmd  = 1'b0;
    capture   = 1'b0;
    timedOut  = 1'b0;
    unique case (state)
      IDLE: begin
        if (CmdValid) begin
          latchCmd  = 1'b1;
          chanNext  = cmdChanClamped;
          stateNext = REQ;
        end
      end
      REQ: begin
        // An ack coinciding with expiry takes priority over the timeout
        if (ChAck[chanQ]) begin
          capture   = 1'b1;
          stateNext = HOLD;
        end else if (tmoExpired) begin
          timedOut  = 1'b1;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (MemReady) begin
          if (sweepQ && (chanQ != LAST_CH)) begin
            chanNext  = chanQ + 1'b1;
            stateNext = REQ;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      chanQ    <= '0;
      slaveQ   <= '0;
      sweepQ   <= 1'b0;
      ChReq    <= '0;
      CmdReady <= 1'b1;
      MemValid <= 1'b0;
      MemData  <= '0;
      MemSlave <= '0;
      MemChan  <= '0;
      MemErr   <= 1'b0;
    end else begin
      chanQ <= chanNext;
      if (latchCmd) begin
        slaveQ <= CmdSlave;
        sweepQ <= CmdSweep;
      end
      if (capture) begin
        MemData  <= ChData[int'(chanQ) * DATA_W +: DATA_W];
        MemErr   <= 1'b0;
        MemChan  <= chanQ;
        MemSlave <= slaveQ;
      end else if (timedOut) begin
        MemData  <= '0;
        MemErr   <= 1'b1;
        MemChan  <= chanQ;
        MemSlave <= slaveQ;
      end
      ChReq    <= (stateNext == REQ) ? (NUM_CH'(1) << chanNext) : '0;
      CmdReady <= (stateNext == IDLE);
      MemValid <= (stateNext == HOLD);
    end
  end

endmodule

// File: tb/tb_mem_channel_manager.sv
// Directed self-checking bench for mem_channel_manager (4-channel main
// instance plus a 3-channel instance for command channel clamping).
module tb_mem_channel_manager;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  logic        CmdValid, CmdReady, CmdSweep, MemValid, MemReady, MemErr;
  logic [1:0]  CmdChan, CmdSlave, MemSlave, MemChan;
  logic [3:0]  ChReq, ChAck;
  logic [127:0] ChData;
  logic [31:0] MemData;

  mem_channel_manager #(
    .DATA_W (32), .NUM_CH (4), .SLAVE_W (2), .TMO_CYC (4)
  ) dut (
    .Clk (Clk), .Rst_n (Rst_n), .CmdValid (CmdValid), .CmdReady (CmdReady),
    .CmdChan (CmdChan), .CmdSlave (CmdSlave), .CmdSweep (CmdSweep),
    .ChReq (ChReq), .ChAck (ChAck), .ChData (ChData), .MemData (MemData),
    .MemSlave (MemSlave), .MemChan (MemChan), .MemValid (MemValid),
    .MemReady (MemReady), .MemErr (MemErr)
  );

  logic        c3Valid, c3Ready, c3Sweep, c3MemValid, c3MemReady, c3MemErr;
  logic [1:0]  c3Chan, c3Slave, c3MemSlave, c3MemChan;
  logic [2:0]  c3Req, c3Ack;
  logic [23:0] c3Data;
  logic [7:0]  c3MemData;

  mem_channel_manager #(
    .DATA_W (8), .NUM_CH (3), .SLAVE_W (2), .TMO_CYC (4)
  ) dut3 (
    .Clk (Clk), .Rst_n (Rst_n), .CmdValid (c3Valid), .CmdReady (c3Ready),
    .CmdChan (c3Chan), .CmdSlave (c3Slave), .CmdSweep (c3Sweep),
    .ChReq (c3Req), .ChAck (c3Ack), .ChData (c3Data), .MemData (c3MemData),
    .MemSlave (c3MemSlave), .MemChan (c3MemChan), .MemValid (c3MemValid),
    .MemReady (c3MemReady), .MemErr (c3MemErr)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Offers a command for one edge; on return the bench is in cycle 1
  task automatic sendCmd(input logic [1:0] ch, input logic [1:0] sl, input logic sw);
    CmdValid = 1'b1; CmdChan = ch; CmdSlave = sl; CmdSweep = sw;
    tick();
    CmdValid = 1'b0;
  endtask

  initial begin
    CmdValid = 0; CmdChan = 0; CmdSlave = 0; CmdSweep = 0; ChAck = 0; MemReady = 0;
    ChData = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    c3Valid = 0; c3Chan = 0; c3Slave = 0; c3Sweep = 0; c3Ack = 0; c3MemReady = 0;
    c3Data = {8'h12, 8'h11, 8'h10};

    // Reset state
    Rst_n = 1'b0; tick(); tick(); Rst_n = 1'b1;
    check("rst_cmdready", CmdReady, 1);
    check("rst_chreq", ChReq, 0);
    check("rst_memvalid", MemValid, 0);
    check("rst_memdata", MemData, 0);
    check("rst_memerr", MemErr, 0);

    // Single read of channel 2
    sendCmd(2'd2, 2'b10, 1'b0);
    check("t1_chreq", ChReq, 4'b0100);
    check("t1_cmdready_busy", CmdReady, 0);
    ChAck = 4'b0100; tick(); ChAck = 0;
    check("t1_memvalid", MemValid, 1);
    check("t1_memdata", MemData, 32'hA5A5_0002);
    check("t1_memslave", MemSlave, 2'b10);
    check("t1_memchan", MemChan, 2);
    check("t1_memerr", MemErr, 0);
    check("t1_chreq_hold", ChReq, 0);
    MemReady = 1; tick(); MemReady = 0;
    check("t1_cmdready_back", CmdReady, 1);
    check("t1_memvalid_drop", MemValid, 0);

    // Sweep from channel 1 with immediate acks and MemReady held
    ChAck = 4'b1111; MemReady = 1;
    sendCmd(2'd1, 2'b01, 1'b1);
    check("t2_c1_chreq", ChReq, 4'b0010);
    tick();
    check("t2_c2_valid", MemValid, 1);
    check("t2_c2_chan", MemChan, 1);
    check("t2_c2_data", MemData, 32'hA5A5_0001);
    tick();
    check("t2_c3_valid", MemValid, 0);
    check("t2_c3_chreq", ChReq, 4'b0100);
    tick();
    check("t2_c4_valid", MemValid, 1);
    check("t2_c4_chan", MemChan, 2);
    tick(); tick();
    check("t2_c6_valid", MemValid, 1);
    check("t2_c6_chan", MemChan, 3);
    check("t2_c6_data", MemData, 32'hA5A5_0003);
    check("t2_c6_cmdready", CmdReady, 0);
    tick();
    check("t2_c7_cmdready", CmdReady, 1);
    check("t2_c7_valid", MemValid, 0);
    ChAck = 0; MemReady = 0;

    // Timeout on channel 0 after four request cycles
    sendCmd(2'd0, 2'b00, 1'b0);
    tick(); tick(); tick();
    check("t3_c4_chreq", ChReq, 4'b0001);
    check("t3_c4_valid", MemValid, 0);
    tick();
    check("t3_tmo_valid", MemValid, 1);
    check("t3_tmo_err", MemErr, 1);
    check("t3_tmo_data", MemData, 0);
    check("t3_tmo_chreq", ChReq, 0);
    MemReady = 1; tick(); MemReady = 0;

    // Ack on the fourth request cycle beats the timeout
    sendCmd(2'd0, 2'b11, 1'b0);
    tick(); tick(); tick();
    ChAck = 4'b0001; tick(); ChAck = 0;
    check("t3_late_valid", MemValid, 1);
    check("t3_late_err", MemErr, 0);
    check("t3_late_data", MemData, 32'hA5A5_0000);
    MemReady = 1; tick(); MemReady = 0;

    // Backpressure in HOLD with a competing command offered
    sendCmd(2'd3, 2'b01, 1'b0);
    ChAck = 4'b1000; tick(); ChAck = 0;
    CmdValid = 1; CmdChan = 2'd0; CmdSlave = 2'b00; CmdSweep = 0;
    ChData[127:96] = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      check("t4_data_stable", MemData, 32'hA5A5_0003);
      check("t4_valid_held", MemValid, 1);
      check("t4_chreq_zero", ChReq, 0);
      check("t4_cmdready_zero", CmdReady, 0);
      tick();
    end
    ChData[127:96] = 32'hA5A5_0003;
    MemReady = 1; tick(); MemReady = 0;
    check("t4_idle_ready", CmdReady, 1);
    check("t4_idle_chreq", ChReq, 0);
    tick(); CmdValid = 0;
    check("t4_new_chreq", ChReq, 4'b0001);
    ChAck = 4'b0001; tick(); ChAck = 0;
    check("t4_new_chan", MemChan, 0);
    MemReady = 1; tick(); MemReady = 0;

    // Reset while requesting
    sendCmd(2'd1, 2'b00, 1'b0);
    Rst_n = 0; tick(); Rst_n = 1;
    check("t5_req_chreq", ChReq, 0);
    check("t5_req_valid", MemValid, 0);
    check("t5_req_ready", CmdReady, 1);
    ChAck = 4'b0010; tick(); tick(); ChAck = 0;
    check("t5_req_nostray", MemValid, 0);

    // Reset while holding a result
    sendCmd(2'd2, 2'b10, 1'b0);
    ChAck = 4'b0100; tick(); ChAck = 0;
    check("t5_hold_valid_pre", MemValid, 1);
    Rst_n = 0; tick(); Rst_n = 1;
    check("t5_hold_valid", MemValid, 0);
    check("t5_hold_ready", CmdReady, 1);
    check("t5_hold_data", MemData, 0);
    tick(); tick();
    check("t5_hold_nostray", MemValid, 0);

    // Stray ack on another channel is ignored
    sendCmd(2'd1, 2'b11, 1'b0);
    ChAck = 4'b1000; tick();
    check("t6_stray_valid", MemValid, 0);
    check("t6_stray_chreq", ChReq, 4'b0010);
    ChAck = 4'b1010; tick(); ChAck = 0;
    check("t6_chan", MemChan, 1);
    check("t6_data", MemData, 32'hA5A5_0001);
    check("t6_slave", MemSlave, 2'b11);
    MemReady = 1; tick(); MemReady = 0;

    // Out-of-range command channel clamps to the last channel (3-channel instance)
    c3Valid = 1; c3Chan = 2'd3; c3Slave = 2'b01; tick(); c3Valid = 0;
    check("t6_clamp_req", c3Req, 3'b100);
    c3Ack = 3'b100; tick(); c3Ack = 0;
    check("t6_clamp_valid", c3MemValid, 1);
    check("t6_clamp_chan", c3MemChan, 2);
    check("t6_clamp_data", c3MemData, 8'h12);
    c3MemReady = 1; tick(); c3MemReady = 0;
    check("t6_clamp_ready", c3Ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
